// File: rtl/gs_pkg.sv
// Shared definitions for the grayscale frame sequencer: state encoding and default sizing.
package gs_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARM   = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_ERR   = 3'd5;

  localparam int PIX_W_DEF   = 17;
  localparam int TIMEOUT_DEF = 1023;
  localparam int TO_W_DEF    = 10;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_ARM   = ST_ARM,
    S_RUN   = ST_RUN,
    S_DRAIN = ST_DRAIN,
    S_DONE  = ST_DONE,
    S_ERR   = ST_ERR
  } state_e;

endpackage

// File: rtl/gs_watchdog.sv
// Stall watchdog: a down-counter reloaded on clear, decremented on enable, flagging expiry at zero.
module gs_watchdog #(
  parameter int TIMEOUT = 1023,
  parameter int TO_W    = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [TO_W-1:0] LOAD = TO_W'(TIMEOUT);

  // Counts remaining idle cycles; the owner keeps clr_i high outside an active frame.
  logic [TO_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= LOAD;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - TO_W'(1);
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/gs_frame_sequencer.sv
// Frame controller for reader -> grayscaler -> writer: starts a frame, counts output pixels,
// waits for the writer to commit, and reports done or a sticky error.
module gs_frame_sequencer
  import gs_pkg::*;
#(
  parameter int PIX_W   = PIX_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TO_W    = TO_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PIX_W-1:0] pix_total,
  output logic             rd_en,
  output logic             rd_pause,
  output logic             gs_enable,
  input  logic             gs_pause,
  input  logic             gs_valid,
  input  logic             gs_done,
  output logic             wr_en,
  input  logic             wr_done,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [PIX_W-1:0] pix_cnt
);

  state_e           state_q, state_d;
  logic [PIX_W-1:0] total_q, total_d, cnt_d;
  logic             err_d;
  logic             running, wd_clr, wd_en, wd_exp;

  assign running = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign wd_clr  = !running || gs_valid;
  assign wd_en   = running && !gs_valid && !gs_pause;

  gs_watchdog #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_wd (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .expired_o(wd_exp)
  );

  always_comb begin
    state_d = state_q;
    total_d = total_q;
    cnt_d   = pix_cnt;
    err_d   = err;
    if (abort && (state_q != S_IDLE) && (state_q != S_ERR)) begin
      state_d = S_ERR;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            total_d = pix_total;
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = (pix_total == '0) ? S_ERR : S_ARM;
          end
        end
        S_ARM: state_d = S_RUN;
        S_RUN: begin
          // A valid beat outranks both a pending watchdog expiry and gs_done.
          if (gs_valid) begin
            if (pix_cnt < total_q) cnt_d = pix_cnt + PIX_W'(1);
            if (cnt_d == total_q) state_d = S_DRAIN;
            else if (gs_done)     state_d = S_ERR;
          end else if (gs_done || wd_exp) begin
            state_d = S_ERR;
          end
        end
        S_DRAIN: begin
          if (gs_valid)     state_d = S_ERR;
          else if (wr_done) state_d = S_DONE;
          else if (wd_exp)  state_d = S_ERR;
        end
        S_DONE:  state_d = S_IDLE;
        S_ERR:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    if (state_d == S_ERR) err_d = 1'b1;
  end

  // Outputs are decoded from the next state so they line up with the registered state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      total_q   <= '0;
      pix_cnt   <= '0;
      err       <= 1'b0;
      rd_en     <= 1'b0;
      rd_pause  <= 1'b0;
      gs_enable <= 1'b0;
      wr_en     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      total_q   <= total_d;
      pix_cnt   <= cnt_d;
      err       <= err_d;
      rd_en     <= (state_d == S_RUN);
      rd_pause  <= (state_d == S_RUN) && gs_pause;
      gs_enable <= (state_d == S_ARM) || (state_d == S_RUN);
      wr_en     <= (state_d == S_ARM) || (state_d == S_RUN) || (state_d == S_DRAIN);
      busy      <= (state_d != S_IDLE);
      done      <= (state_d == S_DONE);
    end
  end

endmodule

// File: tb/tb_gs_frame_sequencer.sv
// Directed bench for gs_frame_sequencer: hand-computed expectations for normal frames,
// back-pressure, watchdog timeout, abort, zero-length frames, ignored start and mid-frame reset.
module tb_gs_frame_sequencer;

  localparam int PIX_W = 17;

  // Packed output view: {rd_en, rd_pause, gs_enable, wr_en, busy, done, err}
  localparam logic [6:0] O_IDLE   = 7'b0000000;
  localparam logic [6:0] O_IDLE_E = 7'b0000001;
  localparam logic [6:0] O_ARM    = 7'b0011100;
  localparam logic [6:0] O_RUN    = 7'b1011100;
  localparam logic [6:0] O_RUN_P  = 7'b1111100;
  localparam logic [6:0] O_DRAIN  = 7'b0001100;
  localparam logic [6:0] O_DONE   = 7'b0000110;
  localparam logic [6:0] O_ERR    = 7'b0000101;

  logic             clk = 1'b0;
  logic             rst, start, abort, gs_pause, gs_valid, gs_done, wr_done;
  logic [PIX_W-1:0] pix_total;
  logic             rd_en, rd_pause, gs_enable, wr_en, busy, done, err;
  logic [PIX_W-1:0] pix_cnt;
  logic [6:0]       outs;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int rd_hi;
  int base;

  assign outs = {rd_en, rd_pause, gs_enable, wr_en, busy, done, err};

  gs_frame_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .pix_total(pix_total),
    .rd_en    (rd_en),
    .rd_pause (rd_pause),
    .gs_enable(gs_enable),
    .gs_pause (gs_pause),
    .gs_valid (gs_valid),
    .gs_done  (gs_done),
    .wr_en    (wr_en),
    .wr_done  (wr_done),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .pix_cnt  (pix_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int n);
    pix_total = PIX_W'(n);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic beats(input int n);
    gs_valid = 1'b1;
    for (int i = 0; i < n; i++) step();
    gs_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; gs_pause = 1'b0;
    gs_valid = 1'b0; gs_done = 1'b0; wr_done = 1'b0; pix_total = '0;
    step(); step();
    check_val("reset_outs", 32'(outs), 32'(O_IDLE));
    check_val("reset_cnt", 32'(pix_cnt), 0);
    rst = 1'b0;
    step();

    // 1: 16-pixel frame, valid every cycle, wr_done three cycles after the last beat
    base = done_cnt;
    start_frame(16);
    check_val("t1_arm", 32'(outs), 32'(O_ARM));
    step();
    check_val("t1_run", 32'(outs), 32'(O_RUN));
    rd_hi = 1;
    gs_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      if (rd_en) rd_hi++;
    end
    gs_valid = 1'b0;
    check_val("t1_rd_cycles", 32'(rd_hi), 16);
    check_val("t1_drain", 32'(outs), 32'(O_DRAIN));
    check_val("t1_cnt", 32'(pix_cnt), 16);
    step(); step();
    check_val("t1_wait", 32'(outs), 32'(O_DRAIN));
    wr_done = 1'b1;
    step();
    wr_done = 1'b0;
    check_val("t1_done", 32'(outs), 32'(O_DONE));
    step();
    check_val("t1_idle", 32'(outs), 32'(O_IDLE));
    check_val("t1_done_pulses", 32'(done_cnt - base), 1);

    // 2: 8 pixels with a 5-cycle pause in the middle
    base = done_cnt;
    start_frame(8);
    step();
    beats(4);
    gs_pause = 1'b1;
    check_val("t2_pause_lag", 32'(rd_pause), 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_val("t2_paused", 32'(outs), 32'(O_RUN_P));
    end
    gs_pause = 1'b0;
    gs_valid = 1'b1;
    step();
    check_val("t2_resume", 32'(outs), 32'(O_RUN));
    beats(3);
    check_val("t2_drain", 32'(outs), 32'(O_DRAIN));
    check_val("t2_cnt", 32'(pix_cnt), 8);
    wr_done = 1'b1;
    step();
    wr_done = 1'b0;
    check_val("t2_done", 32'(outs), 32'(O_DONE));
    step();
    check_val("t2_done_pulses", 32'(done_cnt - base), 1);

    // 3: stall after 4 beats; expiry registers after 1023 idle cycles, ERR on the next edge
    base = done_cnt;
    start_frame(8);
    step();
    beats(4);
    for (int i = 0; i < 1023; i++) step();
    check_val("t3_before_to", 32'(outs), 32'(O_RUN));
    step();
    check_val("t3_err", 32'(outs), 32'(O_ERR));
    step();
    check_val("t3_idle", 32'(outs), 32'(O_IDLE_E));
    check_val("t3_cnt", 32'(pix_cnt), 4);
    check_val("t3_no_done", 32'(done_cnt - base), 0);

    // 4: abort alongside beat 6 of 10; abort wins so the count holds at 5
    start_frame(10);
    check_val("t4_err_clr", 32'(outs), 32'(O_ARM));
    step();
    beats(5);
    abort = 1'b1;
    gs_valid = 1'b1;
    step();
    abort = 1'b0;
    gs_valid = 1'b0;
    check_val("t4_err", 32'(outs), 32'(O_ERR));
    check_val("t4_cnt_hold", 32'(pix_cnt), 5);
    step();
    check_val("t4_idle", 32'(outs), 32'(O_IDLE_E));
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_val("t4_abort_idle", 32'(outs), 32'(O_IDLE_E));

    // 5: zero-length frame, then a start pulsed during RUN
    start_frame(0);
    check_val("t5_zero_err", 32'(outs), 32'(O_ERR));
    step();
    check_val("t5_zero_idle", 32'(outs), 32'(O_IDLE_E));
    base = done_cnt;
    start_frame(4);
    step();
    beats(1);
    pix_total = PIX_W'(2);
    start = 1'b1;
    beats(1);
    start = 1'b0;
    check_val("t5_start_ignored", 32'(outs), 32'(O_RUN));
    beats(2);
    check_val("t5_drain", 32'(outs), 32'(O_DRAIN));
    check_val("t5_cnt", 32'(pix_cnt), 4);
    wr_done = 1'b1;
    step();
    wr_done = 1'b0;
    check_val("t5_done", 32'(outs), 32'(O_DONE));
    step();
    check_val("t5_done_pulses", 32'(done_cnt - base), 1);

    // 6: reset in DRAIN, then a clean 4-pixel frame whose last beat coincides with gs_done
    base = done_cnt;
    start_frame(2);
    step();
    beats(2);
    check_val("t6_drain", 32'(outs), 32'(O_DRAIN));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("t6_rst_outs", 32'(outs), 32'(O_IDLE));
    check_val("t6_rst_cnt", 32'(pix_cnt), 0);
    start_frame(4);
    step();
    beats(3);
    gs_done = 1'b1;
    beats(1);
    gs_done = 1'b0;
    check_val("t6_last_done", 32'(outs), 32'(O_DRAIN));
    wr_done = 1'b1;
    step();
    wr_done = 1'b0;
    check_val("t6_done", 32'(outs), 32'(O_DONE));
    step();
    check_val("t6_cnt", 32'(pix_cnt), 4);
    check_val("t6_done_pulses", 32'(done_cnt - base), 1);

    // 7: gs_done before the count completes is an early termination
    start_frame(4);
    step();
    beats(2);
    gs_done = 1'b1;
    step();
    gs_done = 1'b0;
    check_val("t7_early_done", 32'(outs), 32'(O_ERR));
    check_val("t7_cnt", 32'(pix_cnt), 2);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
